// File: rtl/otp_pkg.sv
// rtl/otp_pkg.sv - shared types and constants for the OTP shadow controller
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package otp_pkg;

  // Boot-load sequencer states; DONE is terminal until reset.
  typedef enum logic [1:0] {
    LOAD_REQ  = 2'd0,
    LOAD_WAIT = 2'd1,
    DONE      = 2'd2
  } otp_state_e;

  // Fuse field positions inside shadow word 0.
  localparam int SDD_BIT   = 0;
  localparam int WLOCK_BIT = 1;

  // Counter widths: up to 16 words, read latency up to 4 cycles.
  localparam int IDX_W = 4;
  localparam int LAT_W = 2;

  // Byte distance between consecutive fuse words.
  localparam int WORD_STRIDE = `DATA_WIDTH / 8;

  function automatic int word_stride(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/otp_shadow_ctrl_if.sv
// rtl/otp_shadow_ctrl_if.sv - OTP RAM port bundle (read request/data, byte-enabled write)
interface otp_shadow_ctrl_if #(
  parameter int BUS_WIDTH  = `BUS_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
);

  logic [BUS_WIDTH-1:0]    raddr;
  logic                    ren;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [BUS_WIDTH-1:0]    waddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wen;

  // Requester side: issues reads and writes, receives read data.
  modport master (
    output raddr, ren, waddr, wdata, wen,
    input  rdata
  );

  // Responder side: accepts reads and writes, returns read data.
  modport slave (
    input  raddr, ren, waddr, wdata, wen,
    output rdata
  );

endinterface

// File: rtl/otp_shadow_regs.sv
// rtl/otp_shadow_regs.sv - capture bank holding the shadowed fuse words
module otp_shadow_regs
  import otp_pkg::*;
#(
  parameter int NUM_WORDS  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            clr_i,
  input  logic                            wr_en_i,
  input  logic [IDX_W-1:0]                wr_idx_i,
  input  logic [DATA_WIDTH-1:0]           wr_data_i,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] shadow_o
);

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_d;
    logic                  hit;

    assign hit = wr_en_i && (wr_idx_i == IDX_W'(i));

    // Next value: load the incoming fuse word only when this slot is addressed.
    always_comb begin
      word_d = word_q;
      if (hit) begin
        word_d = wr_data_i;
      end
    end

    // Slot register; cleared so a restarted load never exposes stale fuses.
    always_ff @(posedge clk) begin
      if (clr_i) begin
        word_q <= '0;
      end else begin
        word_q <= word_d;
      end
    end

    assign shadow_o[i*DATA_WIDTH +: DATA_WIDTH] = word_q;
  end

endmodule

// File: rtl/otp_shadow_ctrl.sv
// rtl/otp_shadow_ctrl.sv - boot-time OTP fuse shadow loader and port arbiter
module otp_shadow_ctrl
  import otp_pkg::*;
#(
  parameter int BUS_WIDTH  = `BUS_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_WORDS  = 4,
  parameter int BASE_ADDR  = 'h10,
  parameter int RD_LAT     = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  otp_shadow_ctrl_if.slave                m_ram,
  output logic                            m_ready,
  otp_shadow_ctrl_if.master               s_ram,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] shadow_data,
  output logic                            load_done,
  output logic                            secure_debug_disable,
  output logic                            write_lock,
  output logic                            lock_violation
);

  otp_state_e       state_q, state_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             load_done_q, load_done_d;
  logic             cap_en;
  logic             load_ren;
  logic             done;
  logic             last_word;
  logic [BUS_WIDTH-1:0] load_addr;

  assign done      = (state_q == DONE);
  assign last_word = (word_idx_q == IDX_W'(NUM_WORDS - 1));
  assign load_addr = BUS_WIDTH'(BASE_ADDR)
                   + BUS_WIDTH'(word_idx_q) * BUS_WIDTH'(word_stride(DATA_WIDTH));

  // Sequencer state and counters; reset restarts the load from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD_REQ;
      word_idx_q  <= '0;
      lat_cnt_q   <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      lat_cnt_q   <= lat_cnt_d;
      load_done_q <= load_done_d;
    end
  end

  // Next state: one read request, then wait out the slave latency and capture.
  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    lat_cnt_d   = lat_cnt_q;
    load_done_d = load_done_q;
    cap_en      = 1'b0;
    load_ren    = 1'b0;
    case (state_q)
      LOAD_REQ: begin
        load_ren  = 1'b1;
        lat_cnt_d = LAT_W'(RD_LAT - 1);
        state_d   = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if (lat_cnt_q == '0) begin
          cap_en = 1'b1;
          if (last_word) begin
            state_d     = DONE;
            load_done_d = 1'b1;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
            state_d    = LOAD_REQ;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = LOAD_REQ;
      end
    endcase
  end

  otp_shadow_regs #(
    .NUM_WORDS  (NUM_WORDS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regs (
    .clk       (clk),
    .clr_i     (reset),
    .wr_en_i   (cap_en),
    .wr_idx_i  (word_idx_q),
    .wr_data_i (s_ram.rdata),
    .shadow_o  (shadow_data)
  );

  // Security fields stay at their safe value until the load has finished.
  assign secure_debug_disable = done ? shadow_data[SDD_BIT]   : 1'b1;
  assign write_lock           = done ? shadow_data[WLOCK_BIT] : 1'b1;
  assign load_done            = load_done_q;
  assign m_ready              = done;

  // Port mux: the loader owns the slave port until DONE, then the master passes through.
  always_comb begin
    s_ram.raddr    = load_addr;
    s_ram.ren      = 1'b0;
    s_ram.waddr    = '0;
    s_ram.wdata    = '0;
    s_ram.wen      = '0;
    m_ram.rdata    = '0;
    lock_violation = 1'b0;
    if (done) begin
      s_ram.raddr = m_ram.raddr;
      s_ram.ren   = m_ram.ren;
      m_ram.rdata = s_ram.rdata;
      if (!write_lock) begin
        s_ram.waddr = m_ram.waddr;
        s_ram.wdata = m_ram.wdata;
        s_ram.wen   = m_ram.wen;
      end else begin
        lock_violation = |m_ram.wen;
      end
    end else begin
      s_ram.ren = load_ren;
    end
    if (reset) begin
      s_ram.ren = 1'b0;
    end
  end

endmodule

// File: tb/tb_otp_shadow_ctrl.sv
// tb/tb_otp_shadow_ctrl.sv - randomized self-checking bench for otp_shadow_ctrl
module tb_otp_shadow_ctrl;

  localparam int BW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  otp_shadow_ctrl_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) m_if ();
  otp_shadow_ctrl_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) s_if ();
  otp_shadow_ctrl_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) m2_if ();
  otp_shadow_ctrl_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) s2_if ();

  logic [4*DW-1:0] shadow1;
  logic            m_ready1, done1, sdd1, wl1, lv1;
  logic [2*DW-1:0] shadow2;
  logic            m_ready2, done2, sdd2, wl2, lv2;

  otp_shadow_ctrl #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) u_dut (
    .clk                  (clk),
    .reset                (reset),
    .m_ram                (m_if),
    .m_ready              (m_ready1),
    .s_ram                (s_if),
    .shadow_data          (shadow1),
    .load_done            (done1),
    .secure_debug_disable (sdd1),
    .write_lock           (wl1),
    .lock_violation       (lv1)
  );

  otp_shadow_ctrl #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .NUM_WORDS(2), .RD_LAT(3)) u_dut2 (
    .clk                  (clk),
    .reset                (reset),
    .m_ram                (m2_if),
    .m_ready              (m_ready2),
    .s_ram                (s2_if),
    .shadow_data          (shadow2),
    .load_done            (done2),
    .secure_debug_disable (sdd2),
    .write_lock           (wl2),
    .lock_violation       (lv2)
  );

  logic [DW-1:0] fuse [4];
  logic [DW-1:0] fuse2 [2];

  // Slave memory contents: fuse words in the fuse window, an address-derived pattern elsewhere.
  function automatic logic [DW-1:0] mem1(input logic [BW-1:0] a);
    if (a >= 32'h10 && a < 32'h20 && a[1:0] == 2'b00) return fuse[int'((a - 32'h10) >> 2)];
    return {a[15:0], 16'h5EED};
  endfunction

  function automatic logic [DW-1:0] mem2(input logic [BW-1:0] a);
    if (a >= 32'h10 && a < 32'h18 && a[1:0] == 2'b00) return fuse2[int'((a - 32'h10) >> 2)];
    return {a[15:0], 16'hBEEF};
  endfunction

  // Slave with 1-cycle read latency for the default instance.
  logic          p1_v = 1'b0;
  logic [BW-1:0] p1_addr = '0;
  always @(posedge clk) begin
    p1_v    <= s_if.ren;
    p1_addr <= s_if.raddr;
  end
  assign s_if.rdata = p1_v ? mem1(p1_addr) : '0;

  // Slave with 3-cycle read latency for the second instance.
  logic [2:0]    p2_v = '0;
  logic [BW-1:0] p2_a0 = '0, p2_a1 = '0, p2_a2 = '0;
  always @(posedge clk) begin
    p2_v  <= {p2_v[1:0], s2_if.ren};
    p2_a0 <= s2_if.raddr;
    p2_a1 <= p2_a0;
    p2_a2 <= p2_a1;
  end
  assign s2_if.rdata = p2_v[2] ? mem2(p2_a2) : '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_master();
    int sel;
    m_if.ren = 1'($urandom_range(0, 1));
    sel = $urandom_range(0, 2);
    if (sel == 0) m_if.raddr = 32'h40;
    else if (sel == 1) m_if.raddr = 32'h10 + 4 * $urandom_range(0, 3);
    else m_if.raddr = $urandom;
    m_if.wen   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
    m_if.waddr = $urandom;
    m_if.wdata = $urandom;
  endtask

  // Expected shadow contents: word i is visible once its capture cycle has passed.
  function automatic logic [127:0] exp_shadow(input int c, input int nw, input int lat, input bit second);
    logic [127:0] v = '0;
    for (int i = 0; i < nw; i++)
      if ((i + 1) * (lat + 1) <= c) v[i*DW +: DW] = second ? fuse2[i] : fuse[i];
    return v;
  endfunction

  task automatic check_reset_state();
    check("rst_shadow", shadow1, '0);
    check("rst_done", done1, 1'b0);
    check("rst_ready", m_ready1, 1'b0);
    check("rst_lv", lv1, 1'b0);
    check("rst_sdd", sdd1, 1'b1);
    check("rst_wl", wl1, 1'b1);
    check("rst_sren", s_if.ren, 1'b0);
    check("rst_shadow2", shadow2, '0);
    check("rst_done2", done2, 1'b0);
  endtask

  task automatic run_iter(input bit abort_in);
    bit            abort;
    int            c;
    bit            dn, req, prev_done, prev_ren, wl;
    logic [BW-1:0] prev_addr;
    logic [DW-1:0] exp_rd;
    abort = abort_in;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    drive_master();
    m_if.ren = 1'b1;
    m_if.wen = 4'hF;
    #1;
    check_reset_state();
    reset = 1'b0;
    c = 0;
    prev_done = 1'b0;
    prev_ren  = 1'b0;
    prev_addr = '0;
    while (c < 8 + 12) begin
      drive_master();
      #1;
      dn  = (c >= 4 * 2);
      req = (c % 2 == 0);
      wl  = fuse[0][1];
      if (dn) check("sren", s_if.ren, m_if.ren);
      else    check("sren", s_if.ren, req);
      if (dn) check("sraddr", s_if.raddr, m_if.raddr);
      else if (req) check("load_addr", s_if.raddr, 32'h10 + 4 * (c / 2));
      check("ready", m_ready1, dn);
      check("done", done1, dn);
      check("sdd", sdd1, dn ? fuse[0][0] : 1'b1);
      check("wlock", wl1, dn ? wl : 1'b1);
      exp_rd = (dn && prev_done && prev_ren) ? mem1(prev_addr) : '0;
      check("mrdata", m_if.rdata, exp_rd);
      check("swen", s_if.wen, (dn && !wl) ? m_if.wen : 4'h0);
      check("lockviol", lv1, dn && wl && (m_if.wen != 4'h0));
      if (dn && !wl) begin
        check("swaddr", s_if.waddr, m_if.waddr);
        check("swdata", s_if.wdata, m_if.wdata);
      end
      check("shadow", shadow1, exp_shadow(c, 4, 1, 1'b0));
      check("shadow2", shadow2, exp_shadow(c, 2, 3, 1'b1));
      check("done2", done2, c >= 2 * 4);
      prev_done = dn;
      prev_ren  = m_if.ren;
      prev_addr = m_if.raddr;
      @(negedge clk);
      c++;
      if (abort && c == 5) begin
        abort = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
        c = 0;
        prev_done = 1'b0;
        prev_ren  = 1'b0;
      end
    end
  endtask

  initial begin
    m2_if.raddr = '0; m2_if.ren = 1'b0; m2_if.waddr = '0; m2_if.wdata = '0; m2_if.wen = '0;
    fuse2[0] = 32'h3;
    fuse2[1] = 32'h77;
    drive_master();
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 4; i++) fuse[i] = $urandom;
      if (it == 0 || it == 3) begin
        fuse[0] = 32'h1; fuse[1] = 32'hA5; fuse[2] = 32'h5A; fuse[3] = 32'hFF;
      end
      if (it == 1) fuse[0] = 32'h2;
      if (it == 2) fuse[0] = 32'h0;
      if (it >= 4) fuse2[0] = $urandom;
      run_iter(it == 3 || it == 7);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

endmodule
